onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter sharing the single-port 128-bit on-chip memory (25000 words, 15-bit word address, 16 byte lanes, 1-cycle read latency) between the Nios II data master and a DMA/accelerator master.
- Each master sees an Avalon-MM slave port with waitrequest and readdatavalid.
- The block drives the memory's address/byteenable/chipselect/write/writedata/clken and returns readdata to the winning master.
- At most one access per cycle. Round-robin arbitration.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 128, data width; byteenable width is DATA_W/8.
- DEPTH, 25000, valid words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  DATA_W/8  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  to memory
- mem_readdata  in  DATA_W  from memory (valid 1 cycle after address)
- range_err  out  1  sticky out-of-range / illegal-request flag
- err_clr  in  1  clears range_err

Behaviour:
- Reset (reset_n low, asynchronous): waitrequest both 1, readdatavalid both 0, readdata both 0, mem_chipselect 0, mem_write 0, mem_clken 0, range_err 0, last_grant = 1 (so m0 wins first tie). The cycle after reset release, mem_clken = 1 permanently.
- Request: mN_req = mN_read | mN_write.
- Arbitration is combinational each cycle:
  - Only one requester: it is granted.
  - Both requesting: grant the master not equal to last_grant.
  - last_grant updates on the clock edge only when a grant occurs.
- Granted master: waitrequest = 0 in the same cycle. The request is accepted at that clock edge.
- Non-granted requester: waitrequest = 1; it must hold its signals stable (Avalon rule).
- Idle master (no request): waitrequest = 0.
- Memory mux: mem_* driven combinationally from the granted master; mem_chipselect = grant_valid & in_range.
- mem_write = granted write & in_range. A write is single-cycle; no response is returned.
- Read pipeline:
  - On an accepted in-range read, register rd_pend = 1 and rd_id = master.
  - Next cycle: mX_readdatavalid = 1 for rd_id, mX_readdata = mem_readdata registered-through (combinational pass in that cycle).
  - Latency: accept edge + 1 cycle. Back-to-back reads at 1 per cycle are allowed; a new read may be accepted in the same cycle a prior read returns.
  - readdata of a master holds its last value when readdatavalid = 0.
- Out-of-range (address >= DEPTH):
  - Access is granted, not issued to memory; range_err set.
  - A read still returns readdatavalid next cycle, with readdata = 0.
- Illegal request: read and write asserted together from one master is treated as a write, and range_err is set.
- err_clr: clears range_err the next edge. If a new error occurs in the same cycle, set wins.
- Reset mid-read: pending readdatavalid is discarded (not emitted after reset release).

Optional Feature:
- Macro MEMARB_FIXED_PRIO_EN.
- Defined: fixed priority, m0 always wins over m1 when both request; last_grant is unused.
- Undefined: round-robin as above.
- No port changes either way.

Test Plan:
- Reset, then m0 writes addr 0x0010, be=0xFFFF, data=0x1234…; next cycle m0 reads 0x0010 -> mem_write pulse 1 cycle; readdatavalid on m0 one cycle after read accept with data 0x1234…; m1 signals quiet.
- m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid lands on the correct master 1 cycle after its grant. With MEMARB_FIXED_PRIO_EN, m0 is granted all 6 and m1 waitrequest stays 1.
- m1 write with be=0x000F to 0x0020 after a full-word write of 0xFF…FF, then read -> only low 4 bytes updated.
- m0 read addr 25000 -> no mem_chipselect, readdatavalid next cycle with readdata 0, range_err=1; err_clr pulse -> range_err=0.
- m1 read accepted, reset_n pulsed low before the return cycle -> no readdatavalid after release; all outputs at reset values during reset.
- m0 read and write asserted together on addr 5 -> write performed, range_err=1, no readdatavalid.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port 128-bit on-chip RAM with 1-cycle read latency.
// Optional macro MEMARB_FIXED_PRIO_EN: m0 always wins ties instead of round-robin.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 25000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  range_err,
  input  logic                  err_clr
);

  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  // Handshake: a master's request (read|write) is accepted on the rising edge where
  // its waitrequest is 0; a master held off with waitrequest=1 keeps its signals stable.
  logic                running;
  logic                rd_pend;
  logic                rd_id;
  logic                rd_oor;
  logic [DATA_W-1:0]   hold0;
  logic [DATA_W-1:0]   hold1;
`ifndef MEMARB_FIXED_PRIO_EN
  logic                last_grant;
`endif

  logic                req0, req1;
  logic                grant_valid;
  logic                grant_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_read, sel_write;
  logic                sel_illegal;
  logic                in_range;
  logic [DATA_W-1:0]   ret_data;

  always_comb begin
    req0        = m0_read | m0_write;
    req1        = m1_read | m1_write;
    grant_valid = running & (req0 | req1);
`ifdef MEMARB_FIXED_PRIO_EN
    grant_id    = ~req0;
`else
    grant_id    = (req0 & req1) ? ~last_grant : req1;
`endif
    sel_addr    = grant_id ? m1_address : m0_address;
    // Read+write together counts as a write (and is flagged as an error).
    sel_write   = grant_id ? m1_write : m0_write;
    sel_read    = (grant_id ? m1_read : m0_read) & ~sel_write;
    sel_illegal = grant_id ? (m1_read & m1_write) : (m0_read & m0_write);
    in_range    = {1'b0, sel_addr} < DEPTH_LIM;
  end

  assign mem_address    = sel_addr;
  assign mem_byteenable = grant_id ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant_id ? m1_writedata : m0_writedata;
  assign mem_chipselect = grant_valid & in_range;
  assign mem_write      = grant_valid & sel_write & in_range;
  assign mem_clken      = running;

  assign m0_waitrequest = ~running | (req0 & ~(grant_valid & ~grant_id));
  assign m1_waitrequest = ~running | (req1 & ~(grant_valid & grant_id));

  // Out-of-range reads still complete, returning zero.
  assign ret_data         = rd_oor ? '0 : mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_id;
  assign m1_readdatavalid = rd_pend & rd_id;
  assign m0_readdata      = m0_readdatavalid ? ret_data : hold0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : hold1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running    <= 1'b0;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
      rd_oor     <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
      range_err  <= 1'b0;
`ifndef MEMARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      running <= 1'b1;
`ifndef MEMARB_FIXED_PRIO_EN
      if (grant_valid) last_grant <= grant_id;
`endif
      rd_pend <= grant_valid & sel_read;
      rd_id   <= grant_id;
      rd_oor  <= ~in_range;
      if (m0_readdatavalid) hold0 <= ret_data;
      if (m1_readdatavalid) hold1 <= ret_data;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (grant_valid & (~in_range | sel_illegal)) range_err <= 1'b1;
      else if (err_clr)                            range_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM attached.
module tb_onchip_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic          clk, reset_n, err_clr;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          range_err;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] D1  = 128'h12345678_9abcdef0_0fedcba9_87654321;
  localparam logic [DW-1:0] D5  = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [DW-1:0] DBE = {96'hffffffff_ffffffff_ffffffff, 32'hcafebabe};

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .range_err(range_err), .err_clr(err_clr)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM, byte-lane writes, registered read.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        logic [DW-1:0] w;
        w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : '0;
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
        ram[int'(mem_address)] = w;
      end else begin
        mem_readdata <= ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : '0;
      end
    end
  end

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; err_clr = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = '1; m1_byteenable = '1;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1;
    idle_inputs();
    mem_readdata = '0;
    #2 reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin bad++; $display("FAIL rst_wait got=%b exp=11", {m1_waitrequest, m0_waitrequest}); end
    total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL rst_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
    total++; if ((m0_readdata | m1_readdata) !== '0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", m0_readdata, m1_readdata); end
    total++; if ({mem_chipselect, mem_write, mem_clken, range_err} !== 4'b0000) begin bad++; $display("FAIL rst_mem got=%b exp=0000", {mem_chipselect, mem_write, mem_clken, range_err}); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk); #1;
    total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL clken_after_rst got=%b exp=1", mem_clken); end
    total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b00) begin bad++; $display("FAIL idle_wait got=%b exp=00", {m1_waitrequest, m0_waitrequest}); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_write = 1; m0_address = 15'h0010; m0_byteenable = 16'hffff; m0_writedata = D1;
    #1;
    total++; if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b011) begin bad++; $display("FAIL wr_issue got=%b exp=011", {m0_waitrequest, mem_chipselect, mem_write}); end
    total++; if (mem_address !== 15'h0010 || mem_writedata !== D1) begin bad++; $display("FAIL wr_bus got=%h/%h exp=0010/%h", mem_address, mem_writedata, D1); end
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL m1_quiet_wait got=%b exp=0", m1_waitrequest); end
    @(negedge clk);
    m0_write = 0; m0_read = 1;
    #1;
    total++; if ({mem_chipselect, mem_write} !== 2'b10) begin bad++; $display("FAIL rd_issue got=%b exp=10", {mem_chipselect, mem_write}); end
    @(negedge clk);
    m0_read = 0;
    #1;
    total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01) begin bad++; $display("FAIL rd_rdv got=%b exp=01", {m1_readdatavalid, m0_readdatavalid}); end
    total++; if (m0_readdata !== D1) begin bad++; $display("FAIL rd_data got=%h exp=%h", m0_readdata, D1); end
    total++; if (m1_readdata !== '0) begin bad++; $display("FAIL m1_quiet_data got=%h exp=0", m1_readdata); end
    @(negedge clk); #1;
    total++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== D1) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/%h", m0_readdatavalid, m0_readdata, D1); end
  endtask

  task automatic test_byte_enable();
    @(negedge clk);
    m1_write = 1; m1_address = 15'h0020; m1_byteenable = 16'hffff; m1_writedata = '1;
    @(negedge clk);
    m1_byteenable = 16'h000f; m1_writedata = 128'hcafebabe;
    #1;
    total++; if ({m1_waitrequest, mem_write, mem_byteenable} !== {2'b01, 16'h000f}) begin bad++; $display("FAIL be_issue got=%b/%h exp=01/000f", {m1_waitrequest, mem_write}, mem_byteenable); end
    @(negedge clk);
    m1_write = 0; m1_read = 1; m1_byteenable = 16'hffff;
    @(negedge clk);
    m1_read = 0;
    #1;
    total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) begin bad++; $display("FAIL be_rdv got=%b exp=10", {m1_readdatavalid, m0_readdatavalid}); end
    total++; if (m1_readdata !== DBE) begin bad++; $display("FAIL be_data got=%h exp=%h", m1_readdata, DBE); end
  endtask

  task automatic test_round_robin();
    int prev;
    int cur;
    do_reset();
    prev = -1;
    m0_read = 1; m0_address = 15'h0010;
    m1_read = 1; m1_address = 15'h0020;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
`ifdef MEMARB_FIXED_PRIO_EN
      cur = 0;
`else
      cur = i % 2;
`endif
      total++; if ({m1_waitrequest, m0_waitrequest} !== (cur == 0 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant cyc=%0d got=%b exp_grant=m%0d", i, {m1_waitrequest, m0_waitrequest}, cur); end
      if (prev >= 0) begin
        total++; if ({m1_readdatavalid, m0_readdatavalid} !== (prev == 0 ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_rdv cyc=%0d got=%b exp_m%0d", i, {m1_readdatavalid, m0_readdatavalid}, prev); end
        total++; if ((prev == 0 ? m0_readdata : m1_readdata) !== (prev == 0 ? D1 : DBE)) begin bad++; $display("FAIL rr_data cyc=%0d got=%h/%h", i, m0_readdata, m1_readdata); end
      end
      prev = cur;
    end
    @(negedge clk);
    m0_read = 0; m1_read = 0;
    #1;
    total++; if ({m1_readdatavalid, m0_readdatavalid} !== (prev == 0 ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_last_rdv got=%b exp_m%0d", {m1_readdatavalid, m0_readdatavalid}, prev); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    m0_read = 1; m0_address = 15'd24999;
    #1;
    total++; if (mem_chipselect !== 1'b1) begin bad++; $display("FAIL oor_last_valid_cs got=%b exp=1", mem_chipselect); end
    @(negedge clk);
    m0_address = 15'h0010;
    @(negedge clk);
    m0_address = 15'd25000;
    #1;
    total++; if ({mem_chipselect, mem_write, m0_waitrequest} !== 3'b000) begin bad++; $display("FAIL oor_issue got=%b exp=000", {mem_chipselect, mem_write, m0_waitrequest}); end
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== D1) begin bad++; $display("FAIL oor_prev_data got=%b/%h exp=1/%h", m0_readdatavalid, m0_readdata, D1); end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL oor_err_early got=%b exp=0", range_err); end
    @(negedge clk);
    m0_read = 0;
    #1;
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== '0) begin bad++; $display("FAIL oor_data got=%b/%h exp=1/0", m0_readdatavalid, m0_readdata); end
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", range_err); end
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    #1;
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", range_err); end
    @(negedge clk);
    m1_read = 1; m1_address = 15'd30000; err_clr = 1;
    @(negedge clk);
    m1_read = 0; err_clr = 0;
    #1;
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%b exp=1", range_err); end
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== '0) begin bad++; $display("FAIL oor_m1_data got=%b/%h exp=1/0", m1_readdatavalid, m1_readdata); end
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    m1_read = 1; m1_address = 15'h0020;
    @(posedge clk);
    #1;
    reset_n = 0;
    m1_read = 0;
    #1;
    total++; if ({m1_waitrequest, m0_waitrequest, m1_readdatavalid, m0_readdatavalid} !== 4'b1100) begin bad++; $display("FAIL mid_rst_hs got=%b exp=1100", {m1_waitrequest, m0_waitrequest, m1_readdatavalid, m0_readdatavalid}); end
    total++; if ((m0_readdata | m1_readdata) !== '0 || {mem_chipselect, mem_write, mem_clken, range_err} !== 4'b0000) begin bad++; $display("FAIL mid_rst_out got=%h/%h/%b exp=0", m0_readdata, m1_readdata, {mem_chipselect, mem_write, mem_clken, range_err}); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL mid_rst_no_rdv cyc=%0d got=%b exp=00", i, {m1_readdatavalid, m0_readdatavalid}); end
    end
  endtask

  task automatic test_read_write_together();
    @(negedge clk);
    m0_read = 1; m0_write = 1; m0_address = 15'd5; m0_byteenable = 16'hffff; m0_writedata = D5;
    #1;
    total++; if ({mem_chipselect, mem_write} !== 2'b11) begin bad++; $display("FAIL rw_issue got=%b exp=11", {mem_chipselect, mem_write}); end
    @(negedge clk);
    m0_read = 0; m0_write = 0;
    #1;
    total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL rw_no_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL rw_err got=%b exp=1", range_err); end
    @(negedge clk);
    err_clr = 1; m0_read = 1;
    @(negedge clk);
    err_clr = 0; m0_read = 0;
    #1;
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== D5) begin bad++; $display("FAIL rw_data got=%b/%h exp=1/%h", m0_readdatavalid, m0_readdata, D5); end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL rw_err_clr got=%b exp=0", range_err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_out_of_range();
    test_reset_mid_read();
    test_read_write_together();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
